alu_issue_ctrl: RTL and testbench

- Issue/sequencing stage directly upstream of the integer ALU.
- Accepts one ALU operation per valid/ready handshake from decode and latches its operands and opcode.
- Drives the ALU enable for the correct number of cycles, including multi-cycle shifts signalled by ALU busy.
- Captures the result and compare flags, then presents them to writeback through a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage between decode and the integer ALU: latches one op, drives ALU enable, returns result.
// Optional busy-timeout watchdog enabled by defining ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
    parameter int XLEN           = 32,
    parameter int OP_W           = 5,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic            I_clk,
    input  logic            I_reset_n,
    input  logic            I_in_valid,
    output logic            O_in_ready,
    input  logic [OP_W-1:0] I_in_op,
    input  logic [XLEN-1:0] I_in_s1,
    input  logic [XLEN-1:0] I_in_s2,
    output logic            O_alu_en,
    output logic            O_alu_reset,
    output logic [OP_W-1:0] O_alu_op,
    output logic [XLEN-1:0] O_alu_s1,
    output logic [XLEN-1:0] O_alu_s2,
    input  logic            I_alu_busy,
    input  logic [XLEN-1:0] I_alu_data,
    input  logic            I_alu_lt,
    input  logic            I_alu_ltu,
    input  logic            I_alu_eq,
    output logic            O_out_valid,
    input  logic            I_out_ready,
    output logic [XLEN-1:0] O_out_data,
    output logic            O_out_lt,
    output logic            O_out_ltu,
    output logic            O_out_eq,
    output logic            O_err
);

    // state | meaning
    // IDLE  | ready for a new op
    // ISSUE | ALU enabled for exactly one cycle
    // WAIT  | ALU enable follows busy until the result is ready
    // DONE  | result held for writeback
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   s1_q, s1_d;
    logic [XLEN-1:0]   s2_q, s2_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              lt_q, lt_d;
    logic              ltu_q, ltu_d;
    logic              eq_q, eq_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready;
    logic              alu_en;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        data_d   = data_q;
        lt_d     = lt_q;
        ltu_d    = ltu_q;
        eq_d     = eq_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        alu_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (I_in_valid) begin
                    op_d    = I_in_op;
                    s1_d    = I_in_s1;
                    s2_d    = I_in_s2;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_en  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Enable only while busy so a finished shift is never restarted.
                alu_en = I_alu_busy;
                if (!I_alu_busy) begin
                    data_d  = I_alu_data;
                    lt_d    = I_alu_lt;
                    ltu_d   = I_alu_ltu;
                    eq_d    = I_alu_eq;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
`ifdef ALU_ISSUE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    alu_en  = 1'b0;
                    data_d  = '0;
                    lt_d    = 1'b0;
                    ltu_d   = 1'b0;
                    eq_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                if (I_out_ready) begin
                    in_ready = 1'b1;
                    err_d    = 1'b0;
                    if (I_in_valid) begin
                        op_d    = I_in_op;
                        s1_d    = I_in_s1;
                        s2_d    = I_in_s2;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            data_q  <= '0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            eq_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            data_q  <= data_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            eq_q    <= eq_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign O_in_ready  = in_ready;
    assign O_alu_en    = alu_en;
    assign O_alu_reset = ~I_reset_n;
    assign O_alu_op    = op_q;
    assign O_alu_s1    = s1_q;
    assign O_alu_s2    = s2_q;
    assign O_out_valid = (state_q == S_DONE);
    assign O_out_data  = data_q;
    assign O_out_lt    = lt_q;
    assign O_out_ltu   = ltu_q;
    assign O_out_eq    = eq_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
    assign O_err = err_q;
`else
    logic [CNT_W-1:0] unused_tmo;
    assign unused_tmo = CNT_W'(TIMEOUT_CYCLES) ^ cnt_q ^ {CNT_W{err_q}};
    assign O_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU (single-cycle ops, 1-bit/cycle shifts).
module tb_alu_issue_ctrl;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SLL = 5'd8;
    localparam logic [4:0] OP_SRA = 5'd10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_s1, in_s2;
    logic        alu_en, alu_reset;
    logic [4:0]  alu_op;
    logic [31:0] alu_s1, alu_s2;
    logic        alu_busy;
    logic [31:0] alu_data;
    logic        alu_lt, alu_ltu, alu_eq;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_lt, out_ltu, out_eq;
    logic        err;

    logic        m_busy, force_busy;
    logic [4:0]  m_cnt, m_op;
    logic [31:0] m_acc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .I_clk(clk), .I_reset_n(reset_n),
        .I_in_valid(in_valid), .O_in_ready(in_ready),
        .I_in_op(in_op), .I_in_s1(in_s1), .I_in_s2(in_s2),
        .O_alu_en(alu_en), .O_alu_reset(alu_reset),
        .O_alu_op(alu_op), .O_alu_s1(alu_s1), .O_alu_s2(alu_s2),
        .I_alu_busy(alu_busy), .I_alu_data(alu_data),
        .I_alu_lt(alu_lt), .I_alu_ltu(alu_ltu), .I_alu_eq(alu_eq),
        .O_out_valid(out_valid), .I_out_ready(out_ready),
        .O_out_data(out_data), .O_out_lt(out_lt), .O_out_ltu(out_ltu), .O_out_eq(out_eq),
        .O_err(err)
    );

    assign alu_busy = m_busy | force_busy;

    // Behavioural ALU: registered results; a shift by N stays busy for N+1 enabled cycles.
    always @(posedge clk) begin
        if (alu_reset) begin
            m_busy <= 1'b0; m_cnt <= '0; m_acc <= '0; m_op <= '0;
            alu_data <= '0; alu_lt <= 1'b0; alu_ltu <= 1'b0; alu_eq <= 1'b0;
        end else if (alu_en) begin
            if (!m_busy) begin
                alu_lt  <= $signed(alu_s1) < $signed(alu_s2);
                alu_ltu <= alu_s1 < alu_s2;
                alu_eq  <= alu_s1 == alu_s2;
                case (alu_op)
                    OP_ADD: alu_data <= alu_s1 + alu_s2;
                    OP_SUB: alu_data <= alu_s1 - alu_s2;
                    OP_XOR: alu_data <= alu_s1 ^ alu_s2;
                    OP_SLL, OP_SRA: begin
                        m_busy <= 1'b1; m_cnt <= alu_s2[4:0]; m_acc <= alu_s1; m_op <= alu_op;
                    end
                    default: alu_data <= '0;
                endcase
            end else if (m_cnt == 5'd0) begin
                m_busy   <= 1'b0;
                alu_data <= m_acc;
            end else begin
                m_cnt <= m_cnt - 5'd1;
                m_acc <= (m_op == OP_SLL) ? (m_acc << 1) : 32'($signed(m_acc) >>> 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op in IDLE, returns the edge at which out_valid rose and the count of enabled cycles.
    task automatic run_op(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          output int lat, output int en_cnt);
        in_op = op; in_s1 = s1; in_s2 = s2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_s1 = 32'hDEAD_BEEF; in_s2 = 32'h1234_5678;
        #1;
        lat = 0; en_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (alu_en) en_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_s1 = '0; in_s2 = '0;
        out_ready = 1'b0; force_busy = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({out_valid, in_ready, alu_en, alu_reset, err} !== 5'b01010) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 01010", {out_valid, in_ready, alu_en, alu_reset, err});
        end
        n_cmp++;
        if ({out_data, alu_op, alu_s1, alu_s2, out_lt, out_ltu, out_eq} !== '0) begin
            n_bad++; $display("FAIL reset_data: got data=%h op=%h s1=%h s2=%h", out_data, alu_op, alu_s1, alu_s2);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (alu_reset !== 1'b0) begin n_bad++; $display("FAIL alu_reset_release: got %b want 0", alu_reset); end
    endtask

    task automatic test_add();
        int lat, en;
        out_ready = 1'b1;
        run_op(OP_ADD, 32'd5, 32'd7, lat, en);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++;
        if (out_data !== 32'd12) begin n_bad++; $display("FAIL add_data: got %h want 0000000c", out_data); end
        n_cmp++;
        if ({out_lt, out_ltu, out_eq, alu_en} !== 4'b1100) begin
            n_bad++; $display("FAIL add_flags: got %b want 1100", {out_lt, out_ltu, out_eq, alu_en});
        end
        tick();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL add_handshake: got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_shift();
        int lat, en;
        out_ready = 1'b1;
        run_op(OP_SLL, 32'd1, 32'd4, lat, en);
        n_cmp++;
        if (lat !== 7) begin n_bad++; $display("FAIL sll_latency: got %0d want 7", lat); end
        n_cmp++;
        if (en !== 6) begin n_bad++; $display("FAIL sll_en_cycles: got %0d want 6", en); end
        n_cmp++;
        if (out_data !== 32'd16 || alu_en !== 1'b0) begin
            n_bad++; $display("FAIL sll_data: got %h en=%b want 00000010 en=0", out_data, alu_en);
        end
        tick();
        run_op(OP_SLL, 32'd5, 32'd0, lat, en);
        n_cmp++;
        if (lat !== 3 || en !== 2) begin n_bad++; $display("FAIL sll0_latency: got %0d/%0d want 3/2", lat, en); end
        n_cmp++;
        if (out_data !== 32'd5) begin n_bad++; $display("FAIL sll0_data: got %h want 00000005", out_data); end
        tick();
    endtask

    task automatic test_hold();
        int lat, en;
        out_ready = 1'b0;
        run_op(OP_SUB, 32'd3, 32'd3, lat, en);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL sub_latency: got %0d want 2", lat); end
        in_valid = 1'b1; in_op = OP_ADD; in_s1 = 32'd9; in_s2 = 32'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({out_valid, in_ready, out_eq, out_data, alu_op, alu_en} !== {3'b101, 32'd0, OP_SUB, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b eq=%b data=%h op=%h want v=1 rdy=0 eq=1 data=0 op=%h",
                         i, out_valid, in_ready, out_eq, out_data, alu_op, OP_SUB);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_single_transfer: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || alu_en !== 1'b0) begin
            n_bad++; $display("FAIL hold_idle: got v=%b en=%b want 0 0", out_valid, alu_en);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_ADD; in_s1 = 32'd5; in_s2 = 32'd7;
        tick();
        in_op = OP_XOR; in_s1 = 32'h0000_00F0; in_s2 = 32'h0000_00FF;
        tick(); tick();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b11 || out_data !== 32'd12) begin
            n_bad++; $display("FAIL b2b_first: got v=%b rdy=%b data=%h want 1 1 0000000c", out_valid, in_ready, out_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({alu_en, out_valid} !== 2'b10 || alu_op !== OP_XOR || alu_s1 !== 32'hF0) begin
            n_bad++; $display("FAIL b2b_accept: got en=%b v=%b op=%h s1=%h want 1 0 %h 000000f0", alu_en, out_valid, alu_op, alu_s1, OP_XOR);
        end
        tick(); tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_000F) begin
            n_bad++; $display("FAIL b2b_second: got v=%b data=%h want 1 0000000f", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, en;
        bit seen;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_SRA; in_s1 = 32'h8000_0000; in_s2 = 32'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (alu_reset !== 1'b1) begin n_bad++; $display("FAIL midreset_alu_reset: got %b want 1", alu_reset); end
        tick();
        n_cmp++;
        if ({out_valid, in_ready, alu_en, err} !== 4'b0100 || alu_op !== 5'd0) begin
            n_bad++; $display("FAIL midreset_idle: got v=%b rdy=%b en=%b err=%b op=%h want 0 1 0 0 00", out_valid, in_ready, alu_en, err, alu_op);
        end
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid || alu_en) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_stale: got activity=%b want 0", seen); end
        run_op(OP_SRA, 32'h8000_0000, 32'd20, lat, en);
        n_cmp++;
        if (lat !== 23 || out_data !== 32'hFFFF_F800) begin
            n_bad++; $display("FAIL sra_after_reset: got lat=%0d data=%h want 23 fffff800", lat, out_data);
        end
        tick();
    endtask

`ifdef ALU_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        int lat, en;
        out_ready = 1'b1;
        force_busy = 1'b1;
        run_op(OP_ADD, 32'd1, 32'd1, lat, en);
        n_cmp++;
        if (lat !== 41) begin n_bad++; $display("FAIL timeout_latency: got %0d want 41", lat); end
        n_cmp++;
        if ({out_valid, err, alu_en} !== 3'b110 || out_data !== 32'd0) begin
            n_bad++; $display("FAIL timeout_result: got v=%b err=%b en=%b data=%h want 1 1 0 0", out_valid, err, alu_en, out_data);
        end
        force_busy = 1'b0;
        tick();
        n_cmp++;
        if ({out_valid, err} !== 2'b00) begin
            n_bad++; $display("FAIL timeout_clear: got v=%b err=%b want 0 0", out_valid, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
